// File: rtl/opb_pkg.sv
// Shared types and field widths for the ALU operand-B select stage.
package opb_pkg;

  typedef enum logic [2:0] {
    OPB_REG   = 3'd0,
    OPB_SHAMT = 3'd1,
    OPB_IMM1  = 3'd2,
    OPB_SEXT4 = 3'd3,
    OPB_ZERO  = 3'd4
  } opb_mode_t;

  localparam int SHAMT_W = 3;
  localparam int SIMM_W  = 4;

endpackage

// File: rtl/opb_skid_buf.sv
// Two-entry valid/ready skid buffer: 1-cycle latency, full throughput.
// in_ready comes straight from a register, so downstream stalls never reach upstream combinationally.
module opb_skid_buf #(
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic [W-1:0] main_dat;
  logic         skid_vld;
  logic [W-1:0] skid_dat;
  logic         rdy;
  logic         accept;
  logic         consume;
  logic         skid_nxt;

  assign accept   = in_valid && rdy;
  assign consume  = main_vld && out_ready;
  // skid fills only when main is full and stalled; it drains on any consume
  assign skid_nxt = skid_vld ? !consume : (accept && main_vld && !out_ready);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
      rdy      <= 1'b0;
    end else begin
      if (consume) begin
        if (skid_vld) begin
          main_dat <= skid_dat;
          skid_vld <= 1'b0;
        end else if (accept) begin
          main_dat <= in_data;
        end else begin
          main_vld <= 1'b0;
        end
      end else if (accept) begin
        if (!main_vld) begin
          main_vld <= 1'b1;
          main_dat <= in_data;
        end else begin
          skid_vld <= 1'b1;
          skid_dat <= in_data;
        end
      end
      rdy <= !skid_nxt;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

endmodule

// File: rtl/alu_opb_stage.sv
// Registered operand-B select with writeback forwarding: 1-cycle latency, one operand per cycle.
// Execute stalls are absorbed by a 2-entry skid buffer; in_ready is registered.
module alu_opb_stage
  import opb_pkg::*;
#(
  parameter int DW = 8,
  parameter int IW = 9,
  parameter int RA = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] mach_code,
  input  logic [2:0]    mode,
  input  logic [DW-1:0] rd_addrB,
  input  logic [RA-1:0] src_regB,
  input  logic          fwd_valid,
  input  logic [RA-1:0] fwd_reg,
  input  logic [DW-1:0] fwd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] InALUB,
  output logic          out_fwd
);

  logic [DW-1:0] sel_data;
  logic          sel_fwd;
  logic [DW:0]   held;

  // Illegal mode codes fall to the default and still transfer a zero operand.
  always_comb begin
    sel_data = '0;
    sel_fwd  = 1'b0;
    case (opb_mode_t'(mode))
      OPB_REG: begin
        if (fwd_valid && (fwd_reg == src_regB)) begin
          sel_data = fwd_data;
          sel_fwd  = 1'b1;
        end else begin
          sel_data = rd_addrB;
        end
      end
      OPB_SHAMT: sel_data = {{(DW-SHAMT_W){1'b0}}, mach_code[5:4], mach_code[0]};
      OPB_IMM1:  sel_data = {{(DW-1){1'b0}}, mach_code[0]};
      OPB_SEXT4: sel_data = {{(DW-SIMM_W){mach_code[SIMM_W-1]}}, mach_code[SIMM_W-1:0]};
      default:   sel_data = '0;
    endcase
  end

  generate
    if (IW > 6) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^mach_code[IW-1:6];
    end
  endgenerate

  opb_skid_buf #(.W(DW + 1)) u_skid (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel_data, sel_fwd}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign InALUB  = held[DW:1];
  assign out_fwd = held[0];

endmodule

// File: doc/alu_opb_stage.md
Name: alu_opb_stage

Overview:
- Registered ALU operand-B select stage between decode and execute. Generalises the combinational operand-B mux.
- Parametrised data and instruction width; an encoded mode replaces the isShift/isAdd flags; adds a sign-extended immediate and a writeback forwarding override.
- Result passes through a 2-entry skid buffer with valid/ready handshakes, so execute-side stalls never combinationally reach decode.

Parameters:
- DW, 8, operand/data width in bits (must be >= 4)
- IW, 9, machine-code width in bits (must be >= 6)
- RA, 3, register index width for the forwarding compare

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- in_valid  input  1  decode presents an operand request
- in_ready  output  1  stage can accept a request this cycle
- mach_code  input  IW  instruction word
- mode  input  3  opb_mode_t select
- rd_addrB  input  DW  register-file read data B
- src_regB  input  RA  register index that produced rd_addrB
- fwd_valid  input  1  writeback result valid this cycle
- fwd_reg  input  RA  writeback destination register index
- fwd_data  input  DW  writeback data
- out_valid  output  1  InALUB holds a valid operand
- out_ready  input  1  execute consumes the operand this cycle
- InALUB  output  DW  selected operand B
- out_fwd  output  1  the held operand came from the forward path (debug/perf)

Behaviour:
- Reset, asynchronous while high: out_valid=0, InALUB=0, out_fwd=0, skid buffer empty. in_ready is 1 from the first edge after Reset deasserts.
- A transfer happens on a rising edge with in_valid&&in_ready. The operand is computed combinationally from the inputs sampled at that edge.
- Operand select by mode:
  - OPB_REG(0): if fwd_valid && fwd_reg==src_regB, then fwd_data and out_fwd=1; otherwise rd_addrB and out_fwd=0.
  - OPB_SHAMT(1): zero-extend {mach_code[5:4], mach_code[0]} to DW.
  - OPB_IMM1(2): zero-extend mach_code[0] to DW.
  - OPB_SEXT4(3): sign-extend mach_code[3:0] to DW.
  - OPB_ZERO(4): all zeros.
  - Codes 5–7 are illegal. They produce 0 and are still transferred (no hang).
- out_fwd=0 for every non-REG mode.
- Forwarding is evaluated only in the acceptance cycle. A later fwd_valid does not update data already held.
- Latency: 1 cycle. An operand accepted at edge N is visible on InALUB/out_valid after edge N.
- Full throughput: with out_ready held at 1, one transfer per cycle.
- Skid buffer, entries main (drives outputs) and skid:
  - in_ready = !skid_valid, driven from a register only.
  - Accept while main is empty, or main is draining (out_ready=1): the operand goes to main.
  - Accept while main is full and out_ready=0: the operand goes to skid, and in_ready falls next cycle.
  - Main consumed with skid full: skid moves to main and skid empties, so in_ready rises next cycle.
  - Simultaneous accept and consume with skid empty: main is replaced by the new operand and out_valid stays 1.
  - Ordering is strictly FIFO. No operand is dropped or duplicated.
- out_valid, InALUB and out_fwd stay stable while out_valid && !out_ready.
- Reset mid-stall discards both entries immediately. No transfer completes on the Reset edge.
- Unused mach_code bits above bit 5 are ignored.

Decomposition:
- Package opb_pkg holds: typedef enum logic[2:0] opb_mode_t {OPB_REG, OPB_SHAMT, OPB_IMM1, OPB_SEXT4, OPB_ZERO}; localparam SHAMT_W=3; localparam SIMM_W=4.
- Sub-module opb_skid_buf, parametrised by payload width W=DW+1 (data plus fwd flag). It holds the two-entry handshake logic.
- alu_opb_stage contains the select/forward logic and one opb_skid_buf instance.

Test Plan:
- Reset with in_valid=1 for 3 cycles, then deassert -> out_valid=0 and InALUB=0 throughout Reset; in_ready=1 on the first cycle after Reset.
- mode=SHAMT, mach_code=9'b0_0011_0001, out_ready=1 -> next cycle InALUB=8'h07, out_fwd=0. Then mode=SEXT4, mach_code[3:0]=4'b1010 -> InALUB=8'hFA.
- mode=REG, rd_addrB=8'h11, src_regB=3, fwd_valid=1, fwd_reg=3, fwd_data=8'h5C -> InALUB=8'h5C, out_fwd=1. Repeat with fwd_reg=2 -> InALUB=8'h11, out_fwd=0.
- Backpressure: send A=8'h01, B=8'h02, C=8'h03 back-to-back, out_ready=0 from the cycle A is valid -> A held stable, B goes to skid, in_ready=0, C held at the input. Raise out_ready -> output sequence A, B, C with no loss or duplicate.
- Streaming: 16 REG operands 0..15 with out_ready=1 -> 16 outputs on 16 consecutive cycles, in order, in_ready never drops.
- Assert Reset while both entries are full -> out_valid=0 asynchronously. After release, the first new operand (mode=IMM1, mach_code[0]=1) yields InALUB=8'h01.
